// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Brief    : Shared states, bit positions and command codes for the
//            HD44780-style LCD write sequencer.
// Revision : 1.0  initial release
// ============================================================================
package lcd_pkg;

    // Write-sequencer states
    typedef enum logic [2:0] {
        POWERUP = 3'd0,
        IDLE    = 3'd1,
        SETUP   = 3'd2,
        ENABLE  = 3'd3,
        HOLD    = 3'd4,
        EXEC    = 3'd5
    } lcd_state_t;

    // Field positions inside the LSU LCD control word
    localparam int LCD_ON_BIT = 31;
    localparam int LCD_GO_BIT = 30;
    localparam int LCD_RS_BIT = 9;

    // Instruction codes that need the long execution wait
    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    // Clear and home are the only slow instructions on the controller
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == LCD_CMD_CLEAR) || (data == LCD_CMD_HOME));
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage : lcd_pkg
`default_nettype wire

// File: rtl/lcd_driver.sv
`default_nettype none
// ============================================================================
// Module   : lcd_driver
// Brief    : Converts toggle-triggered LSU LCD commands into timed HD44780
//            write cycles (setup, E pulse, hold, execution wait), with a
//            power-on wait, a one-deep command buffer and sticky overrun.
// Revision : 1.0  initial release
// ============================================================================
module lcd_driver #(
    parameter int unsigned T_POWERON_CYC = 750000,
    parameter int unsigned T_SETUP_CYC   = 2,
    parameter int unsigned T_EN_CYC      = 12,
    parameter int unsigned T_HOLD_CYC    = 2,
    parameter int unsigned T_EXEC_CYC    = 1850,
    parameter int unsigned T_CLEAR_CYC   = 76000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lcd_cmd,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data,
    output logic        o_busy,
    output logic        o_overrun
);
    import lcd_pkg::*;

    // One down-counter covers every phase, so size it for the longest one
    localparam int unsigned C_MAX_CYC = max2(max2(max2(T_POWERON_CYC, T_SETUP_CYC),
                                                  max2(T_EN_CYC, T_HOLD_CYC)),
                                             max2(T_EXEC_CYC, T_CLEAR_CYC));
    localparam int unsigned C_CNT_W   = $clog2(C_MAX_CYC) + 1;

    localparam logic [C_CNT_W-1:0] C_LD_POWERON = C_CNT_W'(T_POWERON_CYC - 1);
    localparam logic [C_CNT_W-1:0] C_LD_SETUP   = C_CNT_W'(T_SETUP_CYC - 1);
    localparam logic [C_CNT_W-1:0] C_LD_EN      = C_CNT_W'(T_EN_CYC - 1);
    localparam logic [C_CNT_W-1:0] C_LD_HOLD    = C_CNT_W'(T_HOLD_CYC - 1);
    localparam logic [C_CNT_W-1:0] C_LD_EXEC    = C_CNT_W'(T_EXEC_CYC - 1);
    localparam logic [C_CNT_W-1:0] C_LD_CLEAR   = C_CNT_W'(T_CLEAR_CYC - 1);

    lcd_state_t         r_state;
    lcd_state_t         w_state_nxt;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_CNT_W-1:0] w_cnt_nxt;

    logic               r_t_q;
    logic               r_pending;
    logic               r_pend_rs;
    logic [7:0]         r_pend_data;
    logic               r_cmd_rs;
    logic [7:0]         r_cmd_data;
    logic               r_lcd_en;
    logic               r_lcd_on;
    logic               r_overrun;

    logic               w_go_evt;
    logic               w_cnt_zero;
    logic               w_load_direct;
    logic               w_load_pend;
    logic               w_buffer;
    logic               w_drop;
    logic               w_unused;

    // Only ON, GO, RS and the data byte carry meaning
    assign w_unused = ^{i_lcd_cmd[29:10], i_lcd_cmd[8]};

    assign w_go_evt   = i_lcd_cmd[LCD_GO_BIT] ^ r_t_q;
    assign w_cnt_zero = (r_cnt == '0);

    // A fresh command goes straight to cmd_q only when nothing is waiting
    assign w_load_direct = w_go_evt && (r_state == IDLE) && !r_pending;
    // The buffered command is promoted when a phase that can start a write ends
    assign w_load_pend   = r_pending && ((r_state == IDLE) ||
                           (((r_state == POWERUP) || (r_state == EXEC)) && w_cnt_zero));
    // Decisions use the pending flag as it stands this cycle
    assign w_buffer      = w_go_evt && !r_pending && !w_load_direct;
    assign w_drop        = w_go_evt && r_pending;

    // State and phase counter register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= POWERUP;
            r_cnt   <= C_LD_POWERON;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and counter reload: each state lasts load+1 cycles
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_zero ? '0 : (r_cnt - 1'b1);
        case (r_state)
            POWERUP: begin
                if (w_cnt_zero) begin
                    if (r_pending) begin
                        w_state_nxt = SETUP;
                        w_cnt_nxt   = C_LD_SETUP;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_load_direct || r_pending) begin
                    w_state_nxt = SETUP;
                    w_cnt_nxt   = C_LD_SETUP;
                end
            end
            SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ENABLE;
                    w_cnt_nxt   = C_LD_EN;
                end
            end
            ENABLE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = C_LD_HOLD;
                end
            end
            HOLD: begin
                if (w_cnt_zero) begin
                    w_state_nxt = EXEC;
                    w_cnt_nxt   = is_long_cmd(r_cmd_rs, r_cmd_data) ? C_LD_CLEAR : C_LD_EXEC;
                end
            end
            EXEC: begin
                if (w_cnt_zero) begin
                    if (r_pending) begin
                        w_state_nxt = SETUP;
                        w_cnt_nxt   = C_LD_SETUP;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Toggle reference and registered power/backlight bit
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_t_q    <= 1'b0;
            r_lcd_on <= 1'b0;
        end else begin
            r_t_q    <= i_lcd_cmd[LCD_GO_BIT];
            r_lcd_on <= i_lcd_cmd[LCD_ON_BIT];
        end
    end

    // One-deep buffer and sticky overrun flag
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pending   <= 1'b0;
            r_pend_rs   <= 1'b0;
            r_pend_data <= 8'h00;
            r_overrun   <= 1'b0;
        end else begin
            if (w_buffer) begin
                r_pending   <= 1'b1;
                r_pend_rs   <= i_lcd_cmd[LCD_RS_BIT];
                r_pend_data <= i_lcd_cmd[7:0];
            end else if (w_load_pend) begin
                r_pending   <= 1'b0;
            end
            if (w_drop) begin
                r_overrun   <= 1'b1;
            end
        end
    end

    // Active command word; drives RS/data from SETUP entry onward
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cmd_rs   <= 1'b0;
            r_cmd_data <= 8'h00;
        end else if (w_load_direct) begin
            r_cmd_rs   <= i_lcd_cmd[LCD_RS_BIT];
            r_cmd_data <= i_lcd_cmd[7:0];
        end else if (w_load_pend) begin
            r_cmd_rs   <= r_pend_rs;
            r_cmd_data <= r_pend_data;
        end
    end

    // Registered E strobe, high exactly while in ENABLE
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_lcd_en <= 1'b0;
        end else begin
            r_lcd_en <= (w_state_nxt == ENABLE);
        end
    end

    assign o_lcd_on   = r_lcd_on;
    assign o_lcd_en   = r_lcd_en;
    assign o_lcd_rs   = r_cmd_rs;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_data = r_cmd_data;
    assign o_busy     = (r_state != IDLE);
    assign o_overrun  = r_overrun;

endmodule : lcd_driver
`default_nettype wire

// File: tb/tb_lcd_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_driver
// Brief    : Self-checking bench for lcd_driver with shortened timings:
//            vector table of single writes, E-pulse scoreboard, and
//            hand-written buffering, overrun and async-reset sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_lcd_driver;

    localparam int unsigned C_POWERON = 20;
    localparam int unsigned C_SETUP   = 2;
    localparam int unsigned C_EN      = 4;
    localparam int unsigned C_HOLD    = 2;
    localparam int unsigned C_EXEC    = 10;
    localparam int unsigned C_CLEAR   = 30;
    localparam int          C_NORM    = C_SETUP + C_EN + C_HOLD + C_EXEC;
    localparam int          C_LONG    = C_SETUP + C_EN + C_HOLD + C_CLEAR;

    logic        clk;
    logic        rst_n;
    logic [31:0] i_lcd_cmd;
    logic        o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_busy, o_overrun;
    logic [7:0]  o_lcd_data;

    lcd_driver #(
        .T_POWERON_CYC (C_POWERON),
        .T_SETUP_CYC   (C_SETUP),
        .T_EN_CYC      (C_EN),
        .T_HOLD_CYC    (C_HOLD),
        .T_EXEC_CYC    (C_EXEC),
        .T_CLEAR_CYC   (C_CLEAR)
    ) u_dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_lcd_cmd  (i_lcd_cmd),
        .o_lcd_on   (o_lcd_on),
        .o_lcd_en   (o_lcd_en),
        .o_lcd_rs   (o_lcd_rs),
        .o_lcd_rw   (o_lcd_rw),
        .o_lcd_data (o_lcd_data),
        .o_busy     (o_busy),
        .o_overrun  (o_overrun)
    );

    typedef struct {
        logic [31:0] word;
        logic        rs;
        logic [7:0]  data;
        int          busy;
    } vec_t;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } sb_t;

    sb_t  q_exp[$];
    vec_t tv[6];

    int   n_err    = 0;
    int   n_checks = 0;

    // E-pulse monitor state
    logic mon_prev_en   = 1'b0;
    int   mon_len       = 0;
    logic mon_unstable  = 1'b0;
    sb_t  mon_cur;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and run the E-pulse scoreboard
    task automatic tick();
        sb_t e;
        @(negedge clk);
        if (!mon_prev_en && o_lcd_en) begin
            if (q_exp.size() == 0) begin
                chk("sb_unexpected_E", 32'd1, 32'd0);
                mon_cur = '{rs: o_lcd_rs, data: o_lcd_data};
            end else begin
                e = q_exp.pop_front();
                chk("sb_rs", {31'd0, o_lcd_rs}, {31'd0, e.rs});
                chk("sb_data", {24'd0, o_lcd_data}, {24'd0, e.data});
                mon_cur = e;
            end
            mon_len      = 1;
            mon_unstable = 1'b0;
        end else if (o_lcd_en) begin
            mon_len++;
        end else if (mon_prev_en) begin
            chk("sb_E_width", mon_len, C_EN);
            chk("sb_E_stable", {31'd0, mon_unstable}, 32'd0);
        end
        if (o_lcd_en && ({o_lcd_rs, o_lcd_data} != {mon_cur.rs, mon_cur.data}))
            mon_unstable = 1'b1;
        mon_prev_en = o_lcd_en;
    endtask

    // Issue a command by flipping GO; optionally expect it on the pins
    task automatic send(input logic [31:0] word, input logic expect_exec);
        logic g;
        g = i_lcd_cmd[30];
        i_lcd_cmd     = word;
        i_lcd_cmd[30] = ~g;
        if (expect_exec)
            q_exp.push_back('{rs: word[9], data: word[7:0]});
    endtask

    // Count busy cycles following reset release (caller releases just after posedge)
    task automatic measure_powerup(input string name);
        int   n;
        logic pins;
        n    = 0;
        pins = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (o_lcd_en || o_lcd_rs || (o_lcd_data != 8'h00) || o_lcd_on) pins = 1'b1;
            if (o_busy) n++;
            else break;
        end
        chk({name, "_busy_len"}, n, C_POWERON);
        chk({name, "_pins_zero"}, {31'd0, pins}, 32'd0);
    endtask

    initial begin
        int   busy_n, first_en;
        logic noisy;

        tv[0] = '{word: 32'h8000_0241, rs: 1'b1, data: 8'h41, busy: C_NORM};
        tv[1] = '{word: 32'h0000_0001, rs: 1'b0, data: 8'h01, busy: C_LONG};
        tv[2] = '{word: 32'h8000_0002, rs: 1'b0, data: 8'h02, busy: C_LONG};
        tv[3] = '{word: 32'h0000_0201, rs: 1'b1, data: 8'h01, busy: C_NORM};
        tv[4] = '{word: 32'h0000_0003, rs: 1'b0, data: 8'h03, busy: C_NORM};
        tv[5] = '{word: 32'h3FFF_FD80, rs: 1'b0, data: 8'h80, busy: C_NORM};

        // ---------------- reset state ----------------
        rst_n     = 1'b0;
        i_lcd_cmd = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",    {31'd0, o_busy},    32'd1);
        chk("rst_en",      {31'd0, o_lcd_en},  32'd0);
        chk("rst_rs",      {31'd0, o_lcd_rs},  32'd0);
        chk("rst_rw",      {31'd0, o_lcd_rw},  32'd0);
        chk("rst_data",    {24'd0, o_lcd_data}, 32'd0);
        chk("rst_on",      {31'd0, o_lcd_on},  32'd0);
        chk("rst_overrun", {31'd0, o_overrun}, 32'd0);

        // ---------------- power-up wait ----------------
        @(posedge clk);
        #1 rst_n = 1'b1;
        measure_powerup("powerup");

        // ---------------- table of single writes ----------------
        for (int k = 0; k < 6; k++) begin
            send(tv[k].word, 1'b1);
            busy_n   = 0;
            first_en = 0;
            for (int i = 1; i <= 100; i++) begin
                tick();
                if (i == 1) begin
                    chk($sformatf("v%0d_rs", k),   {31'd0, o_lcd_rs},   {31'd0, tv[k].rs});
                    chk($sformatf("v%0d_data", k), {24'd0, o_lcd_data}, {24'd0, tv[k].data});
                    chk($sformatf("v%0d_on", k),   {31'd0, o_lcd_on},   {31'd0, tv[k].word[31]});
                end
                if (o_lcd_en && (first_en == 0)) first_en = i;
                if (o_busy) busy_n++;
                else break;
            end
            chk($sformatf("v%0d_busy_len", k), busy_n, tv[k].busy);
            chk($sformatf("v%0d_E_rise", k), first_en, C_SETUP + 1);
            tick();
        end

        // ---------------- payload changes without a toggle ----------------
        noisy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            i_lcd_cmd[9:0] = 10'($urandom);
            tick();
            if (o_busy || o_lcd_en || (o_lcd_rs != tv[5].rs) || (o_lcd_data != tv[5].data))
                noisy = 1'b1;
        end
        chk("no_toggle_no_effect", {31'd0, noisy}, 32'd0);

        // ---------------- buffering: second command during ENABLE ----------------
        send(32'h0000_0241, 1'b1);
        busy_n = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (i == 4) begin
                chk("buf_in_enable", {31'd0, o_lcd_en}, 32'd1);
                send(32'h0000_0242, 1'b1);
            end
            if (i == C_NORM + 1) begin
                chk("buf_setup_rs",   {31'd0, o_lcd_rs},   32'd1);
                chk("buf_setup_data", {24'd0, o_lcd_data}, 32'h42);
                chk("buf_setup_en",   {31'd0, o_lcd_en},   32'd0);
            end
            if (o_busy) busy_n++;
            else break;
        end
        chk("buf_busy_len", busy_n, 2 * C_NORM);
        chk("buf_overrun",  {31'd0, o_overrun}, 32'd0);
        tick();

        // ---------------- overrun: third command dropped ----------------
        send(32'h0000_0210, 1'b1);
        busy_n = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (i == 4) send(32'h0000_0211, 1'b1);
            if (i == 6) send(32'h0000_0212, 1'b0);
            if (i == 8) chk("ovr_set", {31'd0, o_overrun}, 32'd1);
            if (o_busy) busy_n++;
            else break;
        end
        chk("ovr_busy_len", busy_n, 2 * C_NORM);
        chk("ovr_last_data", {24'd0, o_lcd_data}, 32'h11);
        repeat (5) tick();
        chk("ovr_sticky", {31'd0, o_overrun}, 32'd1);

        // ---------------- async reset in the middle of ENABLE ----------------
        send(32'h8000_0277, 1'b1);
        first_en = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (o_lcd_en) begin
                first_en = i;
                break;
            end
        end
        chk("ar_reached_enable", first_en, C_SETUP + 1);
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("ar_en_async",   {31'd0, o_lcd_en},  32'd0);
        chk("ar_busy",       {31'd0, o_busy},    32'd1);
        chk("ar_overrun",    {31'd0, o_overrun}, 32'd0);
        chk("ar_data",       {24'd0, o_lcd_data}, 32'd0);
        mon_prev_en = 1'b0;
        i_lcd_cmd   = 32'h0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        measure_powerup("ar_powerup");
        chk("ar_overrun_after", {31'd0, o_overrun}, 32'd0);

        chk("sb_empty", q_exp.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_lcd_driver
`default_nettype wire

// File: doc/lcd_driver.md
Name: lcd_driver

Overview:
- Downstream consumer of the LSU's LCD control register word (o_io_lcd, 0x1000_4000).
- Turns each software-issued command into a correctly timed HD44780-style write cycle: RS/data setup, E pulse, hold, then execution wait.
- Also performs the power-on wait after reset.
- Outputs drive the LCD pins directly and report busy and overrun status.

Parameters:
- T_POWERON_CYC, 750000: cycles to wait after reset before the first command (15 ms at 50 MHz).
- T_SETUP_CYC, 2: cycles RS/data are stable before E rises.
- T_EN_CYC, 12: cycles E is held high.
- T_HOLD_CYC, 2: cycles RS/data are held after E falls.
- T_EXEC_CYC, 1850: post-write execution wait for normal commands and data.
- T_CLEAR_CYC, 76000: post-write wait for clear/home (RS=0 and data 0x01 or 0x02).

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous active-low reset
- i_lcd_cmd  in  32  LSU LCD register: [31]=ON, [30]=GO toggle, [9]=RS, [7:0]=data; other bits ignored
- o_lcd_on  out  1  LCD power/backlight
- o_lcd_en  out  1  LCD E strobe
- o_lcd_rs  out  1  LCD register select
- o_lcd_rw  out  1  LCD read/write, tied 0 (write only)
- o_lcd_data  out  8  LCD data bus
- o_busy  out  1  1 while state != IDLE
- o_overrun  out  1  sticky; a command was dropped

Behaviour:
- Reset (async, active-low): state=POWERUP; counter loaded; pending=0; o_overrun=0; o_lcd_en/rs/data/on=0; o_busy=1.
- Toggle reference: t_q register samples i_lcd_cmd[30] every cycle; it is initialised at reset to 0.
- Toggle detection: go_evt = i_lcd_cmd[30] ^ t_q.
- go_evt in IDLE with pending=0: latch {RS, data} into cmd_q; enter SETUP next cycle.
- go_evt otherwise, with pending=0: set pending=1; latch word into pend_q (one-deep buffer).
- go_evt otherwise, with pending=1: drop the word; set o_overrun=1, cleared only by reset.
- go_evt during POWERUP counts as "otherwise" and is buffered or dropped by the same rules.
- o_lcd_on is i_lcd_cmd[31], registered with 1-cycle latency. It is independent of the FSM.
- o_lcd_rs and o_lcd_data are driven from cmd_q from SETUP entry until the next command is loaded. They are stable through SETUP, ENABLE and HOLD.
- POWERUP: count T_POWERON_CYC cycles, then go to IDLE, or to SETUP if pending.
- IDLE: o_busy=0; wait for a command.
- SETUP: T_SETUP_CYC cycles with E=0, then go to ENABLE.
- ENABLE: o_lcd_en=1 (registered) for exactly T_EN_CYC cycles, then go to HOLD.
- HOLD: E=0 for T_HOLD_CYC cycles, then go to EXEC.
- EXEC: wait T_CLEAR_CYC if cmd_q RS=0 and data is 0x01 or 0x02, else T_EXEC_CYC.
- EXEC end with pending=1: move pend_q to cmd_q, clear pending, go directly to SETUP (no IDLE cycle, o_busy stays 1).
- EXEC end with pending=0: go to IDLE.
- A go_evt in the same cycle EXEC ends sees pending as not yet cleared. It is therefore buffered only if pending=0, otherwise dropped with overrun.
- Latency: go_evt in IDLE at cycle N gives SETUP at N+1 and E rising at N+1+T_SETUP_CYC.
- Total busy time per command = T_SETUP+T_EN+T_HOLD+T_EXEC (or T_CLEAR).
- Counter: single down-counter, width $clog2 of the largest parameter + 1. Load value is param-1; advance the state at 0.
- Reset mid-operation: E drops asynchronously; pending and overrun are cleared; the sequence restarts from POWERUP.
- A changing i_lcd_cmd[9:0] without a toggle has no effect on the pins.

Decomposition:
- Shared package lcd_pkg holds:
  - state enum {POWERUP, IDLE, SETUP, ENABLE, HOLD, EXEC};
  - bit-position constants LCD_ON_BIT=31, LCD_GO_BIT=30, LCD_RS_BIT=9;
  - command constants LCD_CMD_CLEAR=8'h01, LCD_CMD_HOME=8'h02.
- No sub-module; the FSM, counter and one-deep buffer live in one module.

Test Plan (overrides: T_POWERON=20, T_SETUP=2, T_EN=4, T_HOLD=2, T_EXEC=10, T_CLEAR=30):
- Power-up: reset released -> o_busy=1 for exactly 20 cycles, then 0; all pins 0 throughout.
- Single write: in IDLE set i_lcd_cmd=0x8000_0241 with bit30 flipped -> RS=1, data=0x41 at N+1; E high on cycles N+3..N+6; o_busy clears after 18 cycles total.
- Clear command: RS=0, data=0x01 with toggle -> EXEC lasts 30 cycles; busy window 38 cycles.
- Buffering: second toggle (data 0x42) during ENABLE of first -> first completes, SETUP for 0x42 starts on the cycle after EXEC ends; no IDLE gap; o_overrun=0.
- Overrun: three toggles while busy -> the 2nd is executed, the 3rd is dropped; o_overrun=1 persists until reset.
- Async reset asserted mid-ENABLE -> o_lcd_en=0 within the same cycle with no clock edge; restart shows a 20-cycle POWERUP; o_overrun=0.
